sram_mem_stage: RTL and testbench

- Memory-access stage of the 5-stage ARM pipeline, directly upstream of the MEM/WB pipeline register.
- Turns EXE-stage load/store requests into two-phase accesses to an external 16-bit SRAM.
- Assembles 32-bit load data and raises a freeze (ready low) to the rest of the pipeline while an access is in flight.
- Forwards the pipeline control and data fields to the MEM/WB register.

---
 rtl/sram_mem_stage_if.sv | 39 +++
 rtl/sram_mem_stage.sv | 126 ++++++++++++
 tb/tb_sram_mem_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_stage_if.sv
// Pipeline-side request/forwarding signals and external 16-bit SRAM pins of the memory stage.
// The master side (EXE stage / SRAM) drives requests and read data; the slave side is the stage.
interface sram_mem_stage_if #(
    parameter int unsigned SRAM_AW = 18
);
    logic [31:0]        pc_in;
    logic               wb_en;
    logic               mem_r_en;
    logic               mem_w_en;
    logic [31:0]        alu_res;
    logic [31:0]        val_rm;
    logic [3:0]         dest;

    logic [31:0]        pc;
    logic               wb_en_out;
    logic               mem_r_en_out;
    logic [31:0]        alu_res_out;
    logic [3:0]         dest_out;
    logic [31:0]        data_mem;
    logic               ready;

    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    modport master (
        output pc_in, wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest, sram_dq_in,
        input  pc, wb_en_out, mem_r_en_out, alu_res_out, dest_out, data_mem, ready,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  pc_in, wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest, sram_dq_in,
        output pc, wb_en_out, mem_r_en_out, alu_res_out, dest_out, data_mem, ready,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_stage.sv
// Memory-access stage: splits 32-bit loads/stores into two timed 16-bit SRAM phases,
// freezes the pipeline while an access is in flight and forwards MEM/WB fields.
module sram_mem_stage #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input logic             clk,
    input logic             rst,
    sram_mem_stage_if.slave bus
);

    localparam int unsigned WORD_AW  = SRAM_AW - 1;
    localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic               wr_q;
    logic [31:0]        data_mem_q;

    logic               req;
    logic [WORD_AW-1:0] word;

    assign req  = bus.mem_r_en | bus.mem_w_en;
    // Offset from the SRAM base in half-word pairs; wraps below BASE_ADDR by truncation.
    assign word = WORD_AW'((bus.alu_res - 32'(BASE_ADDR)) >> 2);

    assign bus.pc           = bus.pc_in;
    assign bus.wb_en_out    = bus.wb_en;
    assign bus.mem_r_en_out = bus.mem_r_en;
    assign bus.alu_res_out  = bus.alu_res;
    assign bus.dest_out     = bus.dest;
    assign bus.data_mem     = data_mem_q;

    // Access sequencer; only the operation type is latched, address/data are read live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            data_mem_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                        wr_q    <= bus.mem_w_en;
                    end
                end
                S_LOW: begin
                    if (cnt_q == LAST_CNT) begin
                        if (!wr_q) begin
                            data_mem_q[15:0] <= bus.sram_dq_in;
                        end
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_HIGH: begin
                    if (cnt_q == LAST_CNT) begin
                        if (!wr_q) begin
                            data_mem_q[31:16] <= bus.sram_dq_in;
                        end
                        state_q <= S_DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // SRAM pins and freeze decode from state, so reset idles them without waiting for a clock.
    always_comb begin
        bus.ready       = 1'b0;
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                bus.ready = ~req;
            end
            S_LOW: begin
                bus.sram_addr = {word, 1'b0};
                if (wr_q) begin
                    bus.sram_dq_out = bus.val_rm[15:0];
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = 1'b0;
                end
            end
            S_HIGH: begin
                bus.sram_addr = {word, 1'b1};
                if (wr_q) begin
                    bus.sram_dq_out = bus.val_rm[31:16];
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = 1'b0;
                end
            end
            S_DONE: begin
                bus.ready = 1'b1;
            end
            default: begin
                bus.ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Directed bench for sram_mem_stage: table of load/store/non-memory transactions against a
// behavioural SRAM, plus reset-mid-write and single-wait-cycle freeze sequences.
`timescale 1ns/1ps
module tb_sram_mem_stage;

    localparam int W = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sram_mem_stage_if #(.SRAM_AW(18)) bus ();
    sram_mem_stage_if #(.SRAM_AW(18)) bus_w1 ();

    sram_mem_stage #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_AW(18)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    sram_mem_stage #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut_w1 (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_w1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] sram [0:(1<<18)-1];
    assign bus.sram_dq_in    = sram[bus.sram_addr];
    assign bus_w1.sram_dq_in = 16'h1234;
    always @(posedge clk) begin
        if (!bus.sram_we_n) sram[bus.sram_addr] <= bus.sram_dq_out;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] alu;
        logic [31:0] val;
        logic [17:0] lo_addr;
        logic [31:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        logic [31:0] pcv;
        pcv = 32'h100 + 32'(idx * 4);
        @(posedge clk); #1;
        bus.pc_in    = pcv;
        bus.wb_en    = v.rd;
        bus.mem_r_en = v.rd;
        bus.mem_w_en = v.wr;
        bus.alu_res  = v.alu;
        bus.val_rm   = v.val;
        bus.dest     = 4'(idx);
        if (!v.rd && !v.wr) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                chk("nomem_ready", 32'(bus.ready), 32'd1);
                chk("nomem_we_n", 32'(bus.sram_we_n), 32'd1);
                chk("nomem_alu_out", bus.alu_res_out, v.alu);
                chk("nomem_data", bus.data_mem, v.exp_data);
            end
        end else begin
            for (int c = 0; c <= 2 * W + 1; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    chk("fwd_pc", bus.pc, pcv);
                    chk("fwd_dest", 32'(bus.dest_out), 32'(idx % 16));
                    chk("fwd_mem_r", 32'(bus.mem_r_en_out), 32'(v.rd));
                    chk("fwd_wb", 32'(bus.wb_en_out), 32'(v.rd));
                    chk("idle_ready", 32'(bus.ready), 32'd0);
                    chk("idle_we_n", 32'(bus.sram_we_n), 32'd1);
                    chk("idle_addr", 32'(bus.sram_addr), 32'd0);
                end else if (c <= 2 * W) begin
                    logic        hi;
                    logic [15:0] half;
                    hi   = (c > W);
                    half = hi ? v.val[31:16] : v.val[15:0];
                    chk("freeze_ready", 32'(bus.ready), 32'd0);
                    chk("phase_addr", 32'(bus.sram_addr), 32'(v.lo_addr | 18'(hi)));
                    chk("phase_we_n", 32'(bus.sram_we_n), 32'(!v.wr));
                    chk("phase_oe", 32'(bus.sram_dq_oe), 32'(v.wr));
                    if (v.wr) chk("phase_dq_out", 32'(bus.sram_dq_out), 32'(half));
                end else begin
                    chk("done_ready", 32'(bus.ready), 32'd1);
                    chk("done_we_n", 32'(bus.sram_we_n), 32'd1);
                    chk("done_addr", 32'(bus.sram_addr), 32'd0);
                    chk("done_data", bus.data_mem, v.exp_data);
                end
            end
        end
    endtask

    vec_t vecs[10];
    int   low_cycles;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4,      32'h00000000};
        vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        18'd4,      32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 18'd0,      32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h0,        18'd0,      32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'd1032, 32'h0,        18'd4,      32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 18'd2,      32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b0, 32'd1028, 32'h0,        18'd2,      32'hCAFEF00D};
        vecs[7] = '{1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 18'h3FFFE,  32'hCAFEF00D};
        vecs[8] = '{1'b1, 1'b0, 32'd1020, 32'h0,        18'h3FFFE,  32'hA5A55A5A};
        vecs[9] = '{1'b0, 1'b0, 32'd7,    32'h0,        18'd0,      32'hA5A55A5A};

        rst_n = 1'b0;
        {bus.pc_in, bus.wb_en, bus.mem_r_en, bus.mem_w_en} = '0;
        {bus.alu_res, bus.val_rm, bus.dest} = '0;
        {bus_w1.pc_in, bus_w1.wb_en, bus_w1.mem_r_en, bus_w1.mem_w_en} = '0;
        {bus_w1.alu_res, bus_w1.val_rm, bus_w1.dest} = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("rst_addr", 32'(bus.sram_addr), 32'd0);
        chk("rst_data", bus.data_mem, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

        // Reset during the high phase of a store: low half lands, high half is lost.
        @(posedge clk); #1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b1;
        bus.alu_res  = 32'd1032;
        bus.val_rm   = 32'h11112222;
        repeat (W + 1) @(posedge clk);
        #2;
        chk("pre_rst_we_n", 32'(bus.sram_we_n), 32'd0);
        chk("pre_rst_addr", 32'(bus.sram_addr), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("mid_rst_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("mid_rst_addr", 32'(bus.sram_addr), 32'd0);
        chk("mid_rst_dq", 32'(bus.sram_dq_out), 32'd0);
        chk("mid_rst_ready", 32'(bus.ready), 32'd0);
        chk("mid_rst_data", bus.data_mem, 32'd0);
        bus.mem_w_en = 1'b0;
        #1;
        chk("mid_rst_ready_noreq", 32'(bus.ready), 32'd1);
        rst_n = 1'b1;
        run_txn('{1'b1, 1'b0, 32'd1032, 32'h0, 18'd4, 32'hDEAD2222}, 10);

        // Single wait cycle per half: freeze must be exactly three cycles.
        @(posedge clk); #1;
        bus_w1.mem_r_en = 1'b1;
        bus_w1.alu_res  = 32'd1024;
        low_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_w1.ready) break;
            low_cycles++;
        end
        chk("w1_freeze_len", 32'(low_cycles), 32'd3);
        chk("w1_done_ready", 32'(bus_w1.ready), 32'd1);
        chk("w1_done_data", bus_w1.data_mem, 32'h12341234);
        @(posedge clk); #1;
        bus_w1.mem_r_en = 1'b0;
        @(negedge clk);
        chk("w1_idle_ready", 32'(bus_w1.ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
